// File: rtl/decim_avg.sv
// Boxcar decimator: averages every 2**LOG2N input samples into one output held in a small FIFO.
// Define DECIM_ROUND_EN to round half up instead of truncating the averaged result.
module decim_avg #(
    parameter int DW         = 8,
    parameter int LOG2N      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [DW-1:0]                 x,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DW-1:0]                 out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int AccW = DW + LOG2N;

    logic [AccW-1:0]  acc;
    logic [LOG2N-1:0] cnt;
    logic             last;
    logic [DW-1:0]    result;

    logic [DW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             pop;
    logic             push_ok;

    assign last = in_valid && (cnt == '1);

`ifdef DECIM_ROUND_EN
    // One extra bit so adding N/2 to a full accumulator cannot wrap.
    logic [AccW:0] sum;
    assign sum    = {1'b0, acc} + {{(LOG2N + 1){1'b0}}, x} + (AccW + 1)'(2 ** (LOG2N - 1));
    assign result = DW'(sum >> LOG2N);
`else
    logic [AccW-1:0] sum;
    assign sum    = acc + {{LOG2N{1'b0}}, x};
    assign result = DW'(sum >> LOG2N);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (in_valid) begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc + {{LOG2N{1'b0}}, x};
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign full      = (fifo_count == (AW + 1)'(FIFO_DEPTH));
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign push_ok   = last && (!full || pop);
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= result;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push_ok) begin
                fifo_count <= fifo_count - 1'b1;
            end
            if (last && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decim_avg.sv
// Directed, table-driven bench for decim_avg (DW=8, LOG2N=2, FIFO_DEPTH=4).
module tb_decim_avg;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] x;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] fifo_count;
    logic       overflow;

    int checks;
    int errors;

    typedef struct {
        string           name;
        logic [3:0][7:0] s;
        logic [7:0]      exp_trunc;
        logic [7:0]      exp_round;
    } vec_t;

    vec_t vecs[5];

    decim_avg #(.DW(8), .LOG2N(2), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        x         = '0;
        out_ready = 1'b0;
        reset     = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic feed(input logic [7:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            x        = val;
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{"const10", {8'd10, 8'd10, 8'd10, 8'd10}, 8'd10, 8'd10};
        vecs[1] = '{"ramp0123", {8'd3, 8'd2, 8'd1, 8'd0}, 8'd1, 8'd2};
        vecs[2] = '{"max255", {8'd255, 8'd255, 8'd255, 8'd255}, 8'd255, 8'd255};
        vecs[3] = '{"sum11", {8'd5, 8'd3, 8'd2, 8'd1}, 8'd2, 8'd3};
        vecs[4] = '{"sum26", {8'd8, 8'd7, 8'd6, 8'd5}, 8'd6, 8'd7};

        do_reset();
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_count", fifo_count, 0);
        check("reset_ovf", overflow, 0);

        // Table-driven single blocks: one result, then pop it.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 4; i++) begin
                in_valid = 1'b1;
                x        = vecs[v].s[i];
                step();
                if (i < 3) check({vecs[v].name, "_cnt_mid"}, fifo_count, 0);
            end
            in_valid = 1'b0;
            check({vecs[v].name, "_valid"}, out_valid, 1);
`ifdef DECIM_ROUND_EN
            check({vecs[v].name, "_data"}, out_data, vecs[v].exp_round);
`else
            check({vecs[v].name, "_data"}, out_data, vecs[v].exp_trunc);
`endif
            check({vecs[v].name, "_count"}, fifo_count, 1);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check({vecs[v].name, "_popped"}, fifo_count, 0);
            check({vecs[v].name, "_nvalid"}, out_valid, 0);
        end

        // Stalled consumer: fifth block is dropped and overflow sticks.
        do_reset();
        for (int b = 1; b <= 4; b++) feed(8'(8 * b), 4);
        check("ovf_full_count", fifo_count, 4);
        check("ovf_not_yet", overflow, 0);
        check("ovf_stall_data", out_data, 8);
        feed(8'd40, 4);
        check("ovf_count_after5", fifo_count, 4);
        check("ovf_set", overflow, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain_valid", out_valid, 1);
            check("ovf_drain_data", out_data, 8 * (i + 1));
            step();
        end
        out_ready = 1'b0;
        check("ovf_drained", fifo_count, 0);
        check("ovf_sticky", overflow, 1);

        // Async reset mid-block discards the partial sum and clears overflow.
        feed(8'd50, 2);
        #2;
        reset = 1'b0;
        #1;
        check("arst_ovf", overflow, 0);
        check("arst_count", fifo_count, 0);
        check("arst_valid", out_valid, 0);
        step();
        check("arst_hold_count", fifo_count, 0);
        reset = 1'b1;
        feed(8'd20, 4);
        check("arst_after_count", fifo_count, 1);
        check("arst_after_data", out_data, 20);

        // Full FIFO with a pop on the same edge as the fifth push.
        do_reset();
        for (int b = 1; b <= 4; b++) feed(8'(8 * b), 4);
        feed(8'd40, 3);
        in_valid  = 1'b1;
        x         = 8'd40;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("fullpop_count", fifo_count, 4);
        check("fullpop_ovf", overflow, 0);
        check("fullpop_head", out_data, 16);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("fullpop_drain", out_data, 8 * (i + 2));
            step();
        end
        out_ready = 1'b0;
        check("fullpop_empty", fifo_count, 0);

        // Gapped input: only the fourth valid sample completes the block.
        do_reset();
        begin
            logic [6:0] pat;
            int         seen;
            pat  = 7'b1101001;
            seen = 0;
            for (int i = 0; i < 7; i++) begin
                in_valid = pat[i];
                x        = pat[i] ? 8'd4 : 8'd99;
                step();
                if (pat[i]) seen++;
                check("gap_count", fifo_count, (seen == 4) ? 1 : 0);
            end
            in_valid = 1'b0;
            check("gap_data", out_data, 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
